instr_fetch_unit: RTL and testbench

//  Upstream neighbour of the main control decoder in the RISC-KGP datapath.

---
 rtl/instr_fetch_unit_if.sv | 23 ++
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 tb/tb_instr_fetch_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and imem (slave).
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC / instruction register owner: one imem fetch per instruction, held until execute retires it.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  instr_fetch_unit_if.master imem,
  output logic [31:0]       instr,
  output logic [4:0]        opcode,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              ex_done,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              fetch_err,
  output logic              align_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;
  localparam logic [1:0] StErr  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4_q;
  logic [31:0]       instr_q, instr_d;
  logic              req_q, valid_q;
  logic              fetch_err_q, fetch_err_d;
  logic              align_err_q, align_err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    fetch_err_d = fetch_err_q;
    align_err_d = align_err_q;
    case (state_q)
      StIdle: begin
        if (!halt) begin
          state_d = StReq;
          cnt_d   = '0;
        end
      end
      StReq: begin
        // An ack on the final allowed cycle still completes the fetch.
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          cnt_d   = '0;
          state_d = StHold;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = StErr;
          fetch_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StHold: begin
        if (ex_done) begin
          if (br_taken) begin
            pc_d = {br_target[ADDR_W-1:2], 2'b00};
            if (br_target[1:0] != 2'b00) begin
              align_err_d = 1'b1;
            end
          end else begin
            pc_d = pc_q + ADDR_W'(4);
          end
          cnt_d   = '0;
          state_d = halt ? StIdle : StReq;
        end
      end
      default: state_d = StErr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pc_q        <= RESET_PC;
      pc_plus4_q  <= RESET_PC + ADDR_W'(4);
      instr_q     <= '0;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      fetch_err_q <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      pc_plus4_q  <= pc_d + ADDR_W'(4);
      instr_q     <= instr_d;
      req_q       <= (state_d == StReq);
      valid_q     <= (state_d == StHold);
      fetch_err_q <= fetch_err_d;
      align_err_q <= align_err_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign opcode         = instr_q[31:27];
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_plus4_q;
  assign fetch_err      = fetch_err_q;
  assign align_err      = align_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed corner cases plus randomized traffic vs. a model.
module tb_instr_fetch_unit;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic [31:0] instr;
  logic [4:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ex_done;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fetch_err;
  logic        align_err;

  instr_fetch_unit_if #(.ADDR_W(32)) imem_bus ();

  instr_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .halt        (halt),
    .imem        (imem_bus),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .ex_done     (ex_done),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .fetch_err   (fetch_err),
    .align_err   (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: which phase of the instruction's life we are in, plus architectural values.
  localparam int PIdle = 0, PFetch = 1, PHold = 2, PDead = 3;
  int          ph;
  int          m_wait;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_ferr;
  logic        m_aerr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = PIdle; m_wait = 0; m_pc = 32'h0; m_instr = 32'h0; m_ferr = 1'b0; m_aerr = 1'b0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else begin
      case (ph)
        PIdle: if (!halt) begin ph = PFetch; m_wait = 0; end
        PFetch: begin
          if (imem_bus.imem_ack) begin
            m_instr = imem_bus.imem_rdata;
            ph = PHold;
          end else begin
            m_wait++;
            if (m_wait >= TIMEOUT) begin ph = PDead; m_ferr = 1'b1; end
          end
        end
        PHold: if (ex_done) begin
          if (br_taken) begin
            m_pc = br_target & 32'hFFFF_FFFC;
            if (br_target % 4 != 0) m_aerr = 1'b1;
          end else begin
            m_pc = m_pc + 32'd4;
          end
          m_wait = 0;
          ph = halt ? PIdle : PFetch;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_model();
    chk("imem_req", {31'b0, imem_bus.imem_req}, {31'b0, ph == PFetch});
    if (ph == PFetch) chk("imem_addr", imem_bus.imem_addr, m_pc);
    chk("instr", instr, m_instr);
    chk("opcode", {27'b0, opcode}, {27'b0, m_instr[31:27]});
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, ph == PHold});
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_ferr});
    chk("align_err", {31'b0, align_err}, {31'b0, m_aerr});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    imem_bus.imem_ack = 1'b1;  // stray ack while in reset
    model_reset();
    #1;
    chk("rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_errs", {30'b0, fetch_err, align_err}, 32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    imem_bus.imem_ack = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] data);
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = data;
    cycle();
    imem_bus.imem_ack = 1'b0;
  endtask

  task automatic retire(input logic bt, input logic [31:0] tgt);
    ex_done = 1'b1; br_taken = bt; br_target = tgt;
    cycle();
    ex_done = 1'b0; br_taken = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; halt = 1'b1; ex_done = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0;
    model_reset();
    reset_dut();

    // Basic fetch, ack two cycles after request
    halt = 1'b0;
    cycle();
    chk("t1_req", {31'b0, imem_bus.imem_req}, 32'd1);
    chk("t1_addr", imem_bus.imem_addr, 32'h0);
    cycle();
    cycle();
    chk("t1_not_valid_yet", {31'b0, instr_valid}, 32'd0);
    fetch(32'h2000_0000);
    chk("t1_valid", {31'b0, instr_valid}, 32'd1);
    chk("t1_opcode", {27'b0, opcode}, 32'd4);
    chk("t1_pc_plus4", pc_plus4, 32'd4);

    // Branch redirect, then misaligned target
    retire(1'b1, 32'h40);
    chk("t2_pc", pc, 32'h40);
    chk("t2_addr", imem_bus.imem_addr, 32'h40);
    chk("t2_req", {31'b0, imem_bus.imem_req}, 32'd1);
    fetch(32'h1234_5678);
    retire(1'b1, 32'h43);
    chk("t2_pc_aligned", pc, 32'h40);
    chk("t2_align_err", {31'b0, align_err}, 32'd1);
    fetch(32'h8000_0001);
    retire(1'b0, 32'h0);
    chk("t2_align_sticky", {31'b0, align_err}, 32'd1);

    // Wrap at top of address space
    fetch(32'hABCD_0000);
    retire(1'b1, 32'hFFFF_FFFC);
    fetch(32'h0F00_0000);
    chk("t3_pc_top", pc, 32'hFFFF_FFFC);
    chk("t3_pc_plus4_wrap", pc_plus4, 32'h0);
    retire(1'b0, 32'h0);
    chk("t3_pc_wrapped", pc, 32'h0);

    // Halt during HOLD parks in idle; release resumes at next pc
    fetch(32'h5555_5555);
    halt = 1'b1;
    retire(1'b0, 32'h0);
    chk("t5_no_req", {31'b0, imem_bus.imem_req}, 32'd0);
    cycle();
    chk("t5_still_idle", {31'b0, imem_bus.imem_req}, 32'd0);
    halt = 1'b0;
    cycle();
    chk("t5_req", {31'b0, imem_bus.imem_req}, 32'd1);
    chk("t5_addr", imem_bus.imem_addr, 32'h4);

    // Timeout to ERR
    reset_dut();
    cycle();
    repeat (TIMEOUT - 1) cycle();
    chk("t4_req_before_to", {31'b0, imem_bus.imem_req}, 32'd1);
    cycle();
    chk("t4_fetch_err", {31'b0, fetch_err}, 32'd1);
    chk("t4_req_dropped", {31'b0, imem_bus.imem_req}, 32'd0);
    imem_bus.imem_ack = 1'b1;
    cycle();
    imem_bus.imem_ack = 1'b0;
    chk("t4_err_absorbing", {31'b0, instr_valid}, 32'd0);

    // Ack on the last allowed cycle wins over timeout
    reset_dut();
    cycle();
    repeat (TIMEOUT - 1) cycle();
    fetch(32'hCAFE_F00D);
    chk("t4b_valid", {31'b0, instr_valid}, 32'd1);
    chk("t4b_no_err", {31'b0, fetch_err}, 32'd0);

    // Reset mid-REQ, then mid-HOLD
    retire(1'b0, 32'h0);
    reset_dut();
    cycle();
    fetch(32'h1111_2222);
    reset_dut();
    cycle();
    chk("t6_restart_addr", imem_bus.imem_addr, 32'h0);
    chk("t6_restart_req", {31'b0, imem_bus.imem_req}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if (i % 300 == 299) reset_dut();
      halt = ($urandom_range(0, 9) == 0);
      imem_bus.imem_ack = ($urandom_range(0, 2) == 0);
      imem_bus.imem_rdata = $urandom;
      ex_done = ($urandom_range(0, 2) == 0);
      br_taken = $urandom_range(0, 1) == 1;
      br_target = $urandom;
      if ($urandom_range(0, 7) != 0) br_target[1:0] = 2'b00;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
